vmask_arbiter: RTL and testbench
================================

Name: vmask_arbiter

Overview:
- Shares the single pipelined vector mask unit (masku) between N_REQ requesters (lanes, scoreboard, swizzle path) under round-robin arbitration.
- Registers the winning operation into masku and tracks each in-flight op through a latency-matched tag pipeline.
- Routes each masku result back to the originating requester with its tag; enforces a per-requester outstanding-op limit and supports flush.

Parameters:
N_REQ, 4, number of requesters
NUM_ELEMENTS, 32, mask width (bits per vector mask)
OP_W, 3, mask opcode width
TAG_W, 4, requester-supplied tag width
MASKU_LAT, 2, fixed masku latency: mu_issue cycle to result-valid cycle (>=1)
MAX_OUTST, 2, max in-flight ops per requester (>=1)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous reset, active-high
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester grant/accept, one-hot or zero
req_op  input  N_REQ*OP_W  packed opcodes, requester i at [i*OP_W +: OP_W]
req_a  input  N_REQ*NUM_ELEMENTS  packed mask operand A
req_b  input  N_REQ*NUM_ELEMENTS  packed mask operand B
req_tag  input  N_REQ*TAG_W  packed tags
flush  input  1  abort all in-flight ops
mu_issue  output  1  op valid into masku this cycle
mu_op  output  OP_W  opcode to masku
mu_a  output  NUM_ELEMENTS  operand A to masku
mu_b  output  NUM_ELEMENTS  operand B to masku
mu_result  input  NUM_ELEMENTS  masku result, valid MASKU_LAT cycles after mu_issue
rsp_valid  output  N_REQ  one-hot response strobe to owning requester
rsp_data  output  NUM_ELEMENTS  shared response data bus
rsp_tag  output  TAG_W  tag of the response
busy  output  1  any op issued or in flight

Behaviour:
- Reset (RST=1 at edge): rr_ptr=0; all outstanding counters=0; tracking pipe valids=0; mu_issue, mu_op, mu_a, mu_b=0.
- Combinational outputs during reset: req_ready=0, rsp_valid=0, rsp_data=0, rsp_tag=0, busy=0.
- Eligibility: requester i is eligible when req_valid[i]=1 and outst[i]<MAX_OUTST and flush=0 and RST=0.
- Grant selection: first eligible index searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready is combinational, one-hot on that index, zero if none is eligible.
  - req_ready does not depend on req_valid of other requesters beyond this search.
- Handshake: transfer occurs when req_valid[i] & req_ready[i].
  - Requesters hold op/a/b/tag stable until transfer.
  - At most one transfer per cycle.
- On transfer of index g:
  - Next cycle: mu_issue=1; mu_op/mu_a/mu_b hold g's fields.
  - Tracking stage 0 loads {valid=1, id=g, tag}.
  - rr_ptr <= (g+1) mod N_REQ.
- No transfer: mu_issue=0 next cycle, mu_op/a/b hold previous values, rr_ptr unchanged.
- Tracking pipe: MASKU_LAT stages; stage 0 loads in the mu_issue cycle and advances one stage per cycle.
  - The tail is aligned so its valid is high exactly MASKU_LAT cycles after mu_issue.
  - Back-to-back issues give back-to-back responses; ordering is strictly FIFO.
- Response: when the tail is valid, rsp_valid[id]=1, rsp_data=mu_result, rsp_tag=tag.
  - Responses are combinational from the tail and mu_result.
  - There is no backpressure; requesters must accept.
  - When no response: rsp_data=0, rsp_tag=0.
- outst[i]:
  - +1 on transfer from i.
  - -1 on response to i.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTST.
  - A requester at the limit is skipped; arbitration continues to others.
- Throughput: 1 op/cycle sustained. A single requester is limited to MAX_OUTST ops per (MASKU_LAT+1)-cycle window.
- Flush (synchronous, single cycle or held):
  - In the flush cycle: req_ready=0 and rsp_valid=0.
  - Next cycle: all tracking valids=0, mu_issue=0, all outst=0; rr_ptr unchanged.
  - Results still emerging from masku for killed ops are ignored.
- Reset mid-operation: identical to flush, plus rr_ptr=0.
- busy = mu_issue | OR of all tracking valids.

Test Plan:
- Single op: req_valid=4'b0010, op=1, a=0x0000FFFF, b=0x00FF00FF, tag=5 -> req_ready=4'b0010 same cycle; mu_issue next cycle with those fields; at MASKU_LAT=2 after, rsp_valid=4'b0010, rsp_tag=5, rsp_data=mu_result.
- Round-robin fairness: all four valid continuously with MAX_OUTST=2 -> grant order 0,1,2,3,0,1,... with one transfer per cycle; rr_ptr=1 after the first grant.
- Outstanding limit: only req 2 valid continuously, MASKU_LAT=2, MAX_OUTST=2 -> transfers in cycles 0,1; ready=0 in cycles 2,3; response in cycle 3 frees a slot, so ready=1 in cycle 4 (cycle 3 has an add/free-same-cycle check only if ready was high).
- Simultaneous inc/dec: req 0 at outst=1 transfers in the same cycle its earlier op responds -> outst[0] stays 1; no spurious stall next cycle.
- Flush mid-flight: three ops issued in cycles 0-2, flush=1 in cycle 3 -> no rsp_valid in cycle 3 or after for those ops; busy=0 from cycle 4; new request in cycle 4 granted normally.
- Reset mid-operation: RST=1 with 2 ops in flight and rr_ptr=3 -> next cycle all outputs 0, rr_ptr=0; a request from req 3 and req 0 together after reset grants 0 first.

Source files
------------

// File: rtl/vmask_arbiter.sv
// vmask_arbiter: round-robin sharing of one pipelined mask unit between N_REQ
// requesters, with a latency-matched tag pipe that routes results home.
module vmask_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned NUM_ELEMENTS = 32,
  parameter int unsigned OP_W         = 3,
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned MASKU_LAT    = 2,
  parameter int unsigned MAX_OUTST    = 2
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ*OP_W-1:0]           req_op,
  input  logic [N_REQ*NUM_ELEMENTS-1:0]   req_a,
  input  logic [N_REQ*NUM_ELEMENTS-1:0]   req_b,
  input  logic [N_REQ*TAG_W-1:0]          req_tag,
  input  logic                            flush,
  output logic                            mu_issue,
  output logic [OP_W-1:0]                 mu_op,
  output logic [NUM_ELEMENTS-1:0]         mu_a,
  output logic [NUM_ELEMENTS-1:0]         mu_b,
  input  logic [NUM_ELEMENTS-1:0]         mu_result,
  output logic [N_REQ-1:0]                rsp_valid,
  output logic [NUM_ELEMENTS-1:0]         rsp_data,
  output logic [TAG_W-1:0]                rsp_tag,
  output logic                            busy
);

  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned TAIL  = MASKU_LAT;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
  } trk_t;

  logic [ID_W-1:0]         rr_ptr;
  logic [CNT_W-1:0]        outst [N_REQ];
  // Stage 0 is valid in the mu_issue cycle; stage TAIL lines up with mu_result.
  logic [MASKU_LAT:0]      trk_v;
  trk_t                    trk [MASKU_LAT+1];

  logic [N_REQ-1:0]        eligible;
  logic                    grant_any;
  logic [ID_W-1:0]         grant_idx;
  logic [OP_W-1:0]         sel_op;
  logic [NUM_ELEMENTS-1:0] sel_a;
  logic [NUM_ELEMENTS-1:0] sel_b;
  logic [TAG_W-1:0]        sel_tag;
  logic                    rsp_fire;
  logic [N_REQ-1:0]        inc_vec;
  logic [N_REQ-1:0]        dec_vec;

  // Eligibility and round-robin search starting at rr_ptr
  always_comb begin
    logic [ID_W:0] cand;
    eligible  = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && (outst[i] < CNT_W'(MAX_OUTST)) && !flush && !RST;
    end
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!grant_any && eligible[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  // Operand/tag mux for the granted requester
  always_comb begin
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_tag = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_op  = req_op[i*OP_W +: OP_W];
        sel_a   = req_a[i*NUM_ELEMENTS +: NUM_ELEMENTS];
        sel_b   = req_b[i*NUM_ELEMENTS +: NUM_ELEMENTS];
        sel_tag = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Response routing from the pipe tail; killed during flush or reset
  always_comb begin
    rsp_fire  = trk_v[TAIL] && !flush && !RST;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_tag   = '0;
    if (rsp_fire) begin
      rsp_valid[trk[TAIL].id] = 1'b1;
      rsp_data                = mu_result;
      rsp_tag                 = trk[TAIL].tag;
    end
  end

  // Per-requester increment/decrement strobes and busy
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      inc_vec[i] = grant_any && (grant_idx == ID_W'(i));
      dec_vec[i] = rsp_fire && (trk[TAIL].id == ID_W'(i));
    end
    busy = !RST && (mu_issue || (|trk_v));
  end

  // Control state: issue register, pipe valids, pointer, outstanding counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr   <= '0;
      mu_issue <= 1'b0;
      mu_op    <= '0;
      mu_a     <= '0;
      mu_b     <= '0;
      trk_v    <= '0;
      for (int i = 0; i < N_REQ; i++) outst[i] <= '0;
    end else if (flush) begin
      mu_issue <= 1'b0;
      trk_v    <= '0;
      for (int i = 0; i < N_REQ; i++) outst[i] <= '0;
    end else begin
      mu_issue <= grant_any;
      trk_v    <= {trk_v[MASKU_LAT-1:0], grant_any};
      if (grant_any) begin
        mu_op  <= sel_op;
        mu_a   <= sel_a;
        mu_b   <= sel_b;
        rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          outst[i] <= outst[i] + CNT_W'(1);
        end else if (!inc_vec[i] && dec_vec[i]) begin
          outst[i] <= outst[i] - CNT_W'(1);
        end
      end
    end
  end

  // Tag/id payload pipe; qualified entirely by trk_v
  always_ff @(posedge CLK) begin
    trk[0] <= '{id: grant_idx, tag: sel_tag};
    for (int s = 1; s <= MASKU_LAT; s++) trk[s] <= trk[s-1];
  end

endmodule

// File: tb/tb_vmask_arbiter.sv
// Self-checking bench for vmask_arbiter: directed scenarios plus random traffic
// against a queue-based behavioural model.
module tb_vmask_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned NE    = 32;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned LAT   = 2;
  localparam int unsigned MAXO  = 2;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*OP_W-1:0] req_op;
  logic [N_REQ*NE-1:0]   req_a;
  logic [N_REQ*NE-1:0]   req_b;
  logic [N_REQ*TAG_W-1:0] req_tag;
  logic                  flush;
  logic                  mu_issue;
  logic [OP_W-1:0]       mu_op;
  logic [NE-1:0]         mu_a;
  logic [NE-1:0]         mu_b;
  logic [NE-1:0]         mu_result;
  logic [N_REQ-1:0]      rsp_valid;
  logic [NE-1:0]         rsp_data;
  logic [TAG_W-1:0]      rsp_tag;
  logic                  busy;

  always #5 CLK = ~CLK;

  vmask_arbiter #(
    .N_REQ(N_REQ), .NUM_ELEMENTS(NE), .OP_W(OP_W), .TAG_W(TAG_W),
    .MASKU_LAT(LAT), .MAX_OUTST(MAXO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .flush(flush),
    .mu_issue(mu_issue), .mu_op(mu_op), .mu_a(mu_a), .mu_b(mu_b),
    .mu_result(mu_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus state: one pending request per requester
  logic [N_REQ-1:0] v;
  logic [OP_W-1:0]  f_op  [N_REQ];
  logic [NE-1:0]    f_a   [N_REQ];
  logic [NE-1:0]    f_b   [N_REQ];
  logic [TAG_W-1:0] f_tag [N_REQ];
  logic             rst_i;
  logic             flush_i;
  logic [NE-1:0]    res_i;

  // Model: in-flight ops as a FIFO with absolute due cycles
  typedef struct {
    int id;
    int tag;
    int due;
  } ent_t;
  ent_t          mq[$];
  int            m_rr;
  int            m_outst [N_REQ];
  logic          m_mu_issue;
  logic [OP_W-1:0] m_op;
  logic [NE-1:0] m_a;
  logic [NE-1:0] m_b;
  int            cyc;
  bit            regs_known;
  int            m_grant;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fill(input int i);
    v[i]     = 1'b1;
    f_op[i]  = OP_W'($urandom);
    f_a[i]   = $urandom;
    f_b[i]   = $urandom;
    f_tag[i] = TAG_W'($urandom);
  endtask

  // Drive inputs, compare against the model, then advance the model one cycle
  task automatic eval();
    logic [N_REQ-1:0] e_ready;
    logic [N_REQ-1:0] e_rv;
    logic [NE-1:0]    e_rd;
    logic [TAG_W-1:0] e_rt;
    logic             e_busy;
    bit               due;
    ent_t             e;
    for (int i = 0; i < N_REQ; i++) begin
      req_op[i*OP_W +: OP_W]    = f_op[i];
      req_a[i*NE +: NE]         = f_a[i];
      req_b[i*NE +: NE]         = f_b[i];
      req_tag[i*TAG_W +: TAG_W] = f_tag[i];
    end
    req_valid = v;
    RST       = rst_i;
    flush     = flush_i;
    mu_result = res_i;
    #1;
    m_grant = -1;
    if (!rst_i && !flush_i) begin
      for (int k = 0; k < N_REQ; k++) begin
        int idx;
        idx = (m_rr + k) % N_REQ;
        if (m_grant < 0 && v[idx] && m_outst[idx] < MAXO) m_grant = idx;
      end
    end
    e_ready = '0;
    if (m_grant >= 0) e_ready[m_grant] = 1'b1;
    due  = !rst_i && !flush_i && (mq.size() > 0) && (mq[0].due == cyc);
    e_rv = '0;
    e_rd = '0;
    e_rt = '0;
    if (due) begin
      e_rv[mq[0].id] = 1'b1;
      e_rd = res_i;
      e_rt = TAG_W'(mq[0].tag);
    end
    e_busy = !rst_i && (m_mu_issue || (mq.size() > 0));
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("rsp_data", 64'(rsp_data), 64'(e_rd));
    chk("rsp_tag", 64'(rsp_tag), 64'(e_rt));
    chk("busy", 64'(busy), 64'(e_busy));
    if (regs_known) begin
      chk("mu_issue", 64'(mu_issue), 64'(m_mu_issue));
      chk("mu_op", 64'(mu_op), 64'(m_op));
      chk("mu_a", 64'(mu_a), 64'(m_a));
      chk("mu_b", 64'(mu_b), 64'(m_b));
    end
    if (rst_i) begin
      m_rr = 0;
      foreach (m_outst[i]) m_outst[i] = 0;
      mq.delete();
      m_mu_issue = 1'b0;
      m_op = '0;
      m_a = '0;
      m_b = '0;
      regs_known = 1'b1;
    end else if (flush_i) begin
      foreach (m_outst[i]) m_outst[i] = 0;
      mq.delete();
      m_mu_issue = 1'b0;
    end else begin
      if (due) begin
        m_outst[mq[0].id]--;
        void'(mq.pop_front());
      end
      if (m_grant >= 0) begin
        m_outst[m_grant]++;
        e.id  = m_grant;
        e.tag = int'(f_tag[m_grant]);
        e.due = cyc + LAT + 1;
        mq.push_back(e);
        m_mu_issue = 1'b1;
        m_op = f_op[m_grant];
        m_a  = f_a[m_grant];
        m_b  = f_b[m_grant];
        m_rr = (m_grant + 1) % N_REQ;
      end else begin
        m_mu_issue = 1'b0;
      end
    end
    if (m_grant >= 0) v[m_grant] = 1'b0;
    cyc++;
  endtask

  task automatic adv();
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      eval();
      adv();
    end
  endtask

  initial begin
    logic [N_REQ-1:0] one;
    logic [N_REQ-1:0] lim_exp [6];
    one = 4'b0001;
    lim_exp = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      f_op[i] = '0; f_a[i] = '0; f_b[i] = '0; f_tag[i] = '0;
      m_outst[i] = 0;
    end
    rst_i = 1'b1; flush_i = 1'b0; res_i = '0;
    m_rr = 0; m_mu_issue = 1'b0; m_op = '0; m_a = '0; m_b = '0;
    cyc = 0; regs_known = 1'b0;

    idle(2);
    rst_i = 1'b0;
    idle(1);

    // Single op from requester 1
    v[1] = 1'b1; f_op[1] = 3'd1; f_a[1] = 32'h0000FFFF; f_b[1] = 32'h00FF00FF; f_tag[1] = 4'd5;
    eval(); chk("s1_ready", 64'(req_ready), 64'h2); adv();
    eval();
    chk("s1_issue", 64'(mu_issue), 64'h1);
    chk("s1_op", 64'(mu_op), 64'h1);
    chk("s1_a", 64'(mu_a), 64'h0000FFFF);
    chk("s1_b", 64'(mu_b), 64'h00FF00FF);
    adv();
    eval(); adv();
    res_i = 32'hA5A50F0F;
    eval();
    chk("s1_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("s1_rsp_tag", 64'(rsp_tag), 64'h5);
    chk("s1_rsp_data", 64'(rsp_data), 64'hA5A50F0F);
    adv();
    res_i = $urandom;
    idle(2);

    // Round-robin order 0,1,2,3,... after reset
    rst_i = 1'b1; idle(2); rst_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N_REQ; i++) if (!v[i]) fill(i);
      res_i = $urandom;
      eval(); chk("rr_grant", 64'(req_ready), 64'(one << (k % 4))); adv();
    end
    v = '0;
    idle(4);

    // Outstanding limit with requester 2 alone
    for (int c = 0; c < 6; c++) begin
      if (!v[2]) fill(2);
      res_i = $urandom;
      eval(); chk("lim_ready", 64'(req_ready), 64'(lim_exp[c])); adv();
    end
    v = '0;
    idle(5);

    // Same-cycle add and free on requester 0
    fill(0);
    eval(); chk("incdec_ready0", 64'(req_ready), 64'h1); adv();
    idle(2);
    fill(0); res_i = $urandom;
    eval();
    chk("incdec_ready3", 64'(req_ready), 64'h1);
    chk("incdec_rsp3", 64'(rsp_valid), 64'h1);
    adv();
    fill(0);
    eval(); chk("incdec_ready4", 64'(req_ready), 64'h1); adv();
    v = '0;
    idle(5);

    // Flush with three ops in flight
    fill(1); fill(2); fill(3);
    eval(); chk("fl_g0", 64'(req_ready), 64'h2); adv();
    eval(); chk("fl_g1", 64'(req_ready), 64'h4); adv();
    eval(); chk("fl_g2", 64'(req_ready), 64'h8); adv();
    fill(1); flush_i = 1'b1;
    eval();
    chk("fl_rsp3", 64'(rsp_valid), 64'h0);
    chk("fl_ready3", 64'(req_ready), 64'h0);
    adv();
    flush_i = 1'b0;
    eval();
    chk("fl_busy4", 64'(busy), 64'h0);
    chk("fl_ready4", 64'(req_ready), 64'h2);
    chk("fl_rsp4", 64'(rsp_valid), 64'h0);
    adv();
    eval();
    chk("fl_rsp5", 64'(rsp_valid), 64'h0);
    chk("fl_busy5", 64'(busy), 64'h1);
    adv();
    idle(4);

    // Reset mid-operation with rr_ptr at 3
    fill(1);
    eval(); chk("rs_g0", 64'(req_ready), 64'h2); adv();
    fill(2);
    eval(); chk("rs_g1", 64'(req_ready), 64'h4); adv();
    rst_i = 1'b1;
    eval();
    chk("rs_busy_in_reset", 64'(busy), 64'h0);
    chk("rs_ready_in_reset", 64'(req_ready), 64'h0);
    adv();
    rst_i = 1'b0;
    fill(0); fill(3);
    eval();
    chk("rs_issue", 64'(mu_issue), 64'h0);
    chk("rs_busy", 64'(busy), 64'h0);
    chk("rs_grant0", 64'(req_ready), 64'h1);
    chk("rs_rsp", 64'(rsp_valid), 64'h0);
    adv();
    eval(); chk("rs_grant3", 64'(req_ready), 64'h8); adv();
    idle(4);

    // Random traffic, varying request density
    for (int n = 0; n < 4000; n++) begin
      int dens;
      dens = (n < 2000) ? 3 : 1;
      for (int i = 0; i < N_REQ; i++) begin
        if (!v[i] && $urandom_range(0, dens) == 0) fill(i);
      end
      flush_i = ($urandom_range(0, 39) == 0);
      rst_i   = ($urandom_range(0, 199) == 0);
      res_i   = $urandom;
      eval();
      adv();
    end
    flush_i = 1'b0; rst_i = 1'b0; v = '0;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
